// File: rtl/sc_fifo_burst_reader.sv
// Read-side master for a show-ahead single-clock FIFO: drains buffered words into
// sop/eop-framed bursts on a valid/ready stream, flushing partial fills after a timeout.
module sc_fifo_burst_reader #(
   parameter int unsigned FIFO_WORD_WIDTH = 4,
   parameter int unsigned FIFO_DATA_WIDTH = 8,
   parameter int unsigned BURST_LENGTH    = 8,
   parameter int unsigned TIMEOUT_CYCLES  = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       init,
   input  logic [FIFO_DATA_WIDTH-1:0] fifo_q,
   input  logic                       fifo_empty,
   input  logic [FIFO_WORD_WIDTH:0]   fifo_usedw,
   output logic                       fifo_rdack,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FIFO_DATA_WIDTH-1:0] out_data,
   output logic                       out_sop,
   output logic                       out_eop,
   output logic                       busy
);

   localparam int unsigned CW = FIFO_WORD_WIDTH + 1;
   localparam int unsigned TW = 16;
   localparam logic [CW-1:0] BL_W    = CW'(BURST_LENGTH);
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] len;
   logic [TW-1:0] timer;

   logic active;
   logic load;
   logic go_full;
   logic go_timeout;
   logic start;
   logic last_beat;
   logic finish;
   logic busy_nxt;

   // Pop and load the output register together; never pop while clearing or empty.
   assign active     = reset && !init;
   assign load       = active && (state == BURST) && !fifo_empty && (!out_valid || out_ready);
   assign fifo_rdack = load;

   assign go_full    = (fifo_usedw >= BL_W);
   assign go_timeout = TO_EN && (fifo_usedw != '0) && (timer == TO_LAST);
   assign start      = (state == IDLE) && (go_full || go_timeout);
   assign last_beat  = (cnt == len - CW'(1));
   assign finish     = load && last_beat;

   // busy mirrors the next-cycle view of (state==BURST || out_valid)
   assign busy_nxt = start
                   || ((state == BURST) && !finish)
                   || load
                   || (out_valid && !out_ready);

   always_ff @(posedge clk) begin
      if (!reset || init) begin
         state     <= IDLE;
         cnt       <= '0;
         len       <= '0;
         timer     <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         busy <= busy_nxt;

         case (state)
            IDLE: begin
               if (go_full) begin
                  len   <= BL_W;
                  cnt   <= '0;
                  timer <= '0;
                  state <= BURST;
               end else if (go_timeout) begin
                  len   <= fifo_usedw;
                  cnt   <= '0;
                  timer <= '0;
                  state <= BURST;
               end else if (fifo_usedw != '0) begin
                  if (timer != '1) timer <= timer + TW'(1);
               end else begin
                  timer <= '0;
               end
            end
            BURST: begin
               if (load) begin
                  cnt <= cnt + CW'(1);
                  if (last_beat) state <= IDLE;
               end
            end
         endcase

         // Single-register output stage: load on pop, otherwise drain on ready.
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= fifo_q;
            out_sop   <= (cnt == '0);
            out_eop   <= last_beat;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sc_fifo_burst_reader.sv
// Bench for sc_fifo_burst_reader: show-ahead FIFO harness, expected-beat queue built from
// the burst framing rules, per-cycle protocol checks and directed/random stimulus.
module tb_sc_fifo_burst_reader;

   localparam int unsigned BL = 8;
   localparam int unsigned TO = 64;

   typedef struct packed {
      logic [7:0] d;
      logic       sop;
      logic       eop;
   } beat_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [7:0] fifo_q;
   logic       fifo_empty;
   logic [4:0] fifo_usedw;
   logic       fifo_rdack;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_sop;
   logic       out_eop;
   logic       busy;

   // second instance with the timeout disabled, fed a constant partial fill
   logic       nt_rdack, nt_valid, nt_sop, nt_eop, nt_busy;
   logic [7:0] nt_data;
   logic       nt_seen = 1'b0;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   beat_t exp_q[$];

   // FIFO harness
   logic [7:0] mem [16];
   logic [3:0] rp = '0;
   logic [3:0] wp = '0;
   logic [4:0] cnt = '0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;

   // monitor state
   int    rdy_mode     = 0;
   int    rdack_cnt    = 0;
   int    acc_cnt      = 0;
   logic  prev_stall   = 1'b0;
   logic  prev_clear   = 1'b1;
   beat_t prev_beat;
   beat_t got;
   beat_t want;
   logic  gap_en       = 1'b0;
   int    last_eop_cyc = -1;
   int    gap_max      = 0;
   int    gap_seen     = 0;
   int    first_sop_cyc = -1;
   logic  t4_arm       = 1'b0;
   int    nz_cyc       = -1;
   int    rd_cyc       = -1;

   always #5 clk = ~clk;

   sc_fifo_burst_reader #(
      .FIFO_WORD_WIDTH(4), .FIFO_DATA_WIDTH(8), .BURST_LENGTH(BL), .TIMEOUT_CYCLES(TO)
   ) u_dut (
      .clk(clk), .reset(reset), .init(init),
      .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
      .fifo_rdack(fifo_rdack),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
   );

   sc_fifo_burst_reader #(
      .FIFO_WORD_WIDTH(4), .FIFO_DATA_WIDTH(8), .BURST_LENGTH(BL), .TIMEOUT_CYCLES(0)
   ) u_dut_nt (
      .clk(clk), .reset(reset), .init(1'b0),
      .fifo_q(8'h55), .fifo_empty(1'b0), .fifo_usedw(5'd3),
      .fifo_rdack(nt_rdack),
      .out_valid(nt_valid), .out_ready(1'b1), .out_data(nt_data),
      .out_sop(nt_sop), .out_eop(nt_eop), .busy(nt_busy)
   );

   assign fifo_q     = mem[rp];
   assign fifo_empty = (cnt == 5'd0);
   assign fifo_usedw = cnt;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wr_en) begin
         mem[wp] <= wr_data;
         wp      <= wp + 4'd1;
      end
      if (fifo_rdack && cnt != 5'd0) rp <= rp + 4'd1;
      cnt <= cnt + (wr_en ? 5'd1 : 5'd0) - ((fifo_rdack && cnt != 5'd0) ? 5'd1 : 5'd0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle protocol checks and scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      got = {out_data, out_sop, out_eop};
      if (!reset || init) check("rdack_during_clear", 32'(fifo_rdack), 32'(0));
      if (fifo_rdack) begin
         rdack_cnt++;
         check("pop_when_empty", 32'(fifo_empty), 32'(0));
         check("pop_while_stalled", 32'(out_valid && !out_ready), 32'(0));
      end
      if (out_valid) check("busy_with_valid", 32'(busy), 32'(1));
      if (prev_stall && !prev_clear) begin
         check("hold_valid", 32'(out_valid), 32'(1));
         check("hold_beat", 32'(got), 32'(prev_beat));
      end
      if (reset && out_valid && out_sop && first_sop_cyc < 0) first_sop_cyc = cyc;
      if (out_valid && out_ready) begin
         acc_cnt++;
         if (exp_q.size() == 0) begin
            check("extra_beat", 32'(exp_q.size()), 32'(1));
         end else begin
            want = exp_q.pop_front();
            check("beat", 32'(got), 32'(want));
         end
         if (gap_en) begin
            if (out_sop && last_eop_cyc >= 0) begin
               gap_seen++;
               if (cyc - last_eop_cyc - 1 > gap_max) gap_max = cyc - last_eop_cyc - 1;
            end
            if (out_eop) last_eop_cyc = cyc;
         end
      end
      if (t4_arm) begin
         if (nz_cyc < 0 && fifo_usedw != 5'd0) nz_cyc = cyc;
         if (rd_cyc < 0 && fifo_rdack) rd_cyc = cyc;
      end
      if (reset) nt_seen = nt_seen | nt_rdack | nt_valid | nt_busy | nt_sop | nt_eop | (|nt_data);
      prev_stall = out_valid && !out_ready;
      prev_beat  = got;
      prev_clear = !reset || init;
   end

   task automatic step();
      @(posedge clk);
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
   endtask

   // Contiguous writes; expected framing: BL-sized chunks, the tail closes the last burst
   task automatic push_words(input int n, input bit rnd, input logic [7:0] base);
      int    guard;
      beat_t b;
      for (int i = 0; i < n; i++) begin
         guard = 0;
         wr_en = 1'b0;
         while (cnt == 5'd16 && guard < 1000) begin
            step();
            guard++;
         end
         if (guard >= 1000) check("fifo_full_timeout", 32'(guard), 32'(0));
         wr_en   = 1'b1;
         wr_data = rnd ? 8'($urandom) : base + 8'(i);
         b.d     = wr_data;
         b.sop   = ((i % BL) == 0);
         b.eop   = ((i % BL) == BL - 1) || (i == n - 1);
         exp_q.push_back(b);
         step();
      end
      wr_en = 1'b0;
   endtask

   task automatic drain(input string tag);
      int g;
      g = 0;
      while ((exp_q.size() != 0 || busy || cnt != 5'd0) && g < 3000) begin
         step();
         g++;
      end
      check({tag, "_pending_beats"}, 32'(exp_q.size()), 32'(0));
      check({tag, "_usedw"}, 32'(fifo_usedw), 32'(0));
      check({tag, "_busy"}, 32'(busy), 32'(0));
   endtask

   initial begin
      int    rel_cyc;
      int    r0;
      int    a0;
      int    g;
      beat_t b;

      reset     = 1'b0;
      init      = 1'b0;
      out_ready = 1'b1;

      // T1: preload 16 words under reset, hold reset 3 more cycles
      push_words(16, 1'b0, 8'h40);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t1_valid_in_reset", 32'(out_valid), 32'(0));
         check("t1_rdack_in_reset", 32'(fifo_rdack), 32'(0));
         check("t1_busy_in_reset", 32'(busy), 32'(0));
      end
      gap_en = 1'b1;
      reset  = 1'b1;
      #1;
      rel_cyc = cyc;
      check("t1_valid_after_release", 32'(out_valid), 32'(0));
      check("t1_rdack_after_release", 32'(fifo_rdack), 32'(0));
      check("t1_busy_after_release", 32'(busy), 32'(0));

      // T5: the 16 preloaded words leave as two back-to-back 8-beat bursts
      drain("t5");
      check("t1_first_sop_delay_ge2", 32'(first_sop_cyc - rel_cyc >= 2), 32'(1));
      check("t5_gap_count", 32'(gap_seen), 32'(1));
      check("t5_gap_le2", 32'(gap_max <= 2), 32'(1));
      gap_en = 1'b0;

      // T2: 0x10..0x17 with a ready sink
      r0 = rdack_cnt;
      push_words(8, 1'b0, 8'h10);
      drain("t2");
      check("t2_rdack_count", 32'(rdack_cnt - r0), 32'(8));

      // T3: same with alternating ready
      rdy_mode = 1;
      r0 = rdack_cnt;
      push_words(8, 1'b0, 8'h10);
      drain("t3");
      check("t3_rdack_count", 32'(rdack_cnt - r0), 32'(8));
      rdy_mode = 0;
      step();

      // T4: partial fill flushed by the timeout
      t4_arm = 1'b1;
      push_words(3, 1'b0, 8'hA0);
      drain("t4");
      check("t4_timeout_latency", 32'(rd_cyc - nz_cyc), 32'(TO));
      t4_arm = 1'b0;

      // T6: init while the 3rd beat is presented; remaining 5 words form a new burst
      a0 = acc_cnt;
      push_words(8, 1'b1, 8'h00);
      b = exp_q[exp_q.size() - 5];
      b.sop = 1'b1;
      exp_q[exp_q.size() - 5] = b;
      g = 0;
      while (!(acc_cnt == a0 + 2 && out_valid) && g < 200) begin
         step();
         g++;
      end
      check("t6_reach_third_beat", 32'(acc_cnt - a0), 32'(2));
      init = 1'b1;
      step();
      init = 1'b0;
      check("t6_valid_after_init", 32'(out_valid), 32'(0));
      check("t6_busy_after_init", 32'(busy), 32'(0));
      check("t6_rdack_after_init", 32'(fifo_rdack), 32'(0));
      check("t6_words_left", 32'(fifo_usedw), 32'(5));
      drain("t6");
      check("t6_beats_accepted", 32'(acc_cnt - a0), 32'(8));

      // Random lengths, data and sink backpressure
      rdy_mode = 2;
      for (int r = 0; r < 8; r++) begin
         push_words(int'($urandom_range(1, 30)), 1'b1, 8'h00);
         drain("rnd");
      end
      rdy_mode = 0;
      step();

      check("t4_no_output_without_timeout", 32'(nt_seen), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
